// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream framed as len[7:0], len[15:8], then 4*len bytes of
// little-endian words. Each word is written sequentially into the imem write
// port, and the core is released from reset once the whole frame is in.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, the
// frame ends with an XOR checksum byte, and a mismatch aborts into ERR.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is registered. It is 1 in HDR_LO/HDR_HI/DATA/CHK and 0 in DONE/ERR
// and during reset. in_data must be held stable while in_valid=1 and in_ready=0.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE_W     = 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CHK, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = CHK;
`else
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t          state;
    state_t          state_next;
    logic            xfer;
    logic            word_end;
    logic            ready_next;
    logic [16:0]     hdr_len;
    logic [7:0]      len_lo;
    logic [7:0]      csum;
    logic [1:0]      byte_idx;
    logic [23:0]     part;
    logic [ADDR_W:0] len;

    assign xfer     = in_valid && in_ready;
    // Full 16-bit header length, widened by one bit so it can be compared against MAX_WORDS.
    assign hdr_len  = {1'b0, in_data, len_lo};
    assign word_end = (state == DATA) && xfer && (byte_idx == 2'd3);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HDR_LO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; in_ready for the next cycle follows the next state.
    always_comb begin
        state_next = state;
        ready_next = 1'b0;
        case (state)
            HDR_LO: if (xfer) state_next = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    if (hdr_len > MAX_WORDS)     state_next = ERR;
                    else if (hdr_len == 17'd0)   state_next = AFTER_DATA;
                    else                         state_next = DATA;
                end
            end
            DATA: begin
                if (word_end && ((words_loaded + ONE_W) == len)) state_next = AFTER_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (xfer) state_next = (in_data == csum) ? DONE : ERR;
`endif
            default: state_next = state;
        endcase
        ready_next = (state_next != DONE) && (state_next != ERR);
    end

    // Datapath: header capture, word assembly, write strobe, checksum, status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE;
            mem_wdata    <= 32'd0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= 2'd0;
            part         <= 24'd0;
            len_lo       <= 8'd0;
            len          <= '0;
            csum         <= 8'd0;
        end else begin
            mem_we     <= 1'b0;
            in_ready   <= ready_next;
            done       <= (state_next == DONE);
            err        <= (state_next == ERR);
            core_reset <= (state_next != DONE);
            if (xfer) csum <= csum ^ in_data;
            if (xfer && state == HDR_LO) len_lo <= in_data;
            if (xfer && state == HDR_HI) len <= hdr_len[ADDR_W:0];
            if (xfer && state == DATA) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    part[7:0]   <= in_data;
                    2'd1:    part[15:8]  <= in_data;
                    2'd2:    part[23:16] <= in_data;
                    default: begin
                        // Fourth byte: issue the write; the address wraps modulo the imem size.
                        mem_we       <= 1'b1;
                        mem_wdata    <= {in_data, part};
                        mem_addr     <= BASE + words_loaded[ADDR_W-1:0];
                        words_loaded <= words_loaded + ONE_W;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames drive the loader. Each expected imem write
// is queued when its last byte is issued; a monitor pops and compares on
// every mem_we.
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_reset;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [35:0]   exp_q[$];
    logic [31:0]   words[$];
    logic          prev_we  = 1'b0;

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Clock and reset defaults.
    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever #5 clk = ~clk;
    end

    // Watchdog: abort if the run never reaches its summary.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every write strobe must match the head of the queue.
    always @(negedge clk) begin
        logic [35:0] e;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[35:32]);
                check("write_data", mem_wdata, e[31:0]);
            end
            check("we_back_to_back", prev_we, 1'b0);
        end
        prev_we = mem_we;
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words_loaded", words_loaded, 0);
        reset = 1'b1;
    endtask

    // Present one byte after 'gap' idle cycles; it transfers on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1'b1);
    endtask

    // Build a frame from 'words', queue the expected writes, send up to max_bytes.
    task automatic send_frame(input int max_bytes, input int gap_max);
        logic [7:0] fb[$];
        logic [7:0] cs;
        int n;
        n = words.size();
        fb.push_back(n[7:0]);
        fb.push_back(n[15:8]);
        foreach (words[i]) for (int j = 0; j < 4; j++) fb.push_back(words[i][8*j +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs = 8'h00;
        foreach (fb[k]) cs = cs ^ fb[k];
        fb.push_back(cs);
`else
        cs = 8'h00;
`endif
        for (int k = 0; k < fb.size() && k < max_bytes; k++) begin
            if (k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3)
                exp_q.push_back({4'((k - 2) / 4), words[(k - 2) / 4]});
            send_byte(fb[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Status one cycle after the final accepting edge, then a drained scoreboard.
    task automatic check_end(input logic d, input logic e, input int wl);
        check("done", done, d);
        check("err", err, e);
        check("core_reset", core_reset, !d);
        check("in_ready_after", in_ready, !(d || e));
        check("words_loaded", words_loaded, wl);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Directed sequence.
    initial begin
        logic [7:0] ck_frame [0:6];
        ck_frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};

        // Two-word program, back-to-back bytes.
        do_reset();
        words = '{32'h0000_0013, 32'h0010_0093};
        send_frame(1000, 0);
        check_end(1'b1, 1'b0, 2);

        // Empty program: no writes.
        do_reset();
        words.delete();
        send_frame(1000, 0);
        check_end(1'b1, 1'b0, 0);

        // N=17 exceeds 16-word capacity.
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_end(1'b0, 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(negedge clk);
        check("err_hold_in_ready", in_ready, 1'b0);
        check("err_hold_err", err, 1'b1);
        check("err_hold_core_reset", core_reset, 1'b1);
        in_valid = 1'b0;

        // Three-word frame, back-to-back then with random idle gaps.
        do_reset();
        words = '{32'h1122_3344, 32'hCAFE_F00D, 32'h8000_0001};
        send_frame(1000, 0);
        check_end(1'b1, 1'b0, 3);
        do_reset();
        send_frame(1000, 3);
        check_end(1'b1, 1'b0, 3);

        // Reset after 6 bytes of a two-word frame, then resend the full frame.
        do_reset();
        words = '{32'h0000_0013, 32'h0010_0093};
        send_frame(6, 0);
        do_reset();
        send_frame(1000, 0);
        check_end(1'b1, 1'b0, 2);

        // Exactly full memory: 16 words, last address 15.
        do_reset();
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back(32'h1000_0000 + 32'h0101_0101 * i);
        send_frame(1000, 1);
        check_end(1'b1, 1'b0, 16);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match (0x23) and mismatch (0x24).
        do_reset();
        exp_q.push_back({4'd0, 32'hDEAD_BEEF});
        for (int k = 0; k < 7; k++) send_byte(ck_frame[k], 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_end(1'b1, 1'b0, 1);
        do_reset();
        ck_frame[6] = 8'h24;
        exp_q.push_back({4'd0, 32'hDEAD_BEEF});
        for (int k = 0; k < 7; k++) send_byte(ck_frame[k], 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_end(1'b0, 1'b1, 1);
`endif

        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
